ser_rx: RTL

Serial frame receiver: synchronizes an asynchronous serial line, detects start bits, samples `W` data bits LSB-first and checks the stop bit. It presents each received word on a valid/ready output port. It sits directly upstream of the team's parallel-load shift registers and produces the bit stream and word those registers consume. Data is shifted in right-shift order, new bit into the MSB, so the register ends LSB-aligned.

---
 rtl/ser_pkg.sv | 16 +
 rtl/rx_shreg.sv | 28 ++
 rtl/ser_rx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// Shared types and default sizing for the serial receiver.
// Optional parity support is enabled with `SER_RX_PARITY_EN in ser_rx.
package ser_pkg;

  localparam int SER_W         = 8;
  localparam int SER_BIT_TICKS = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } rx_state_e;

endpackage

// File: rtl/rx_shreg.sv
// W-bit right shift register: the serial input enters the MSB, so the word
// ends LSB-aligned after W shifts of an LSB-first stream.
module rx_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_en,
  input  logic         sin,
  output logic [W-1:0] q
);

  logic [W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (shift_en) sr_d = {sin, sr_q[W-1:1]};
  end

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign q = sr_q;

endmodule

// File: rtl/ser_rx.sv
// Serial frame receiver: start/data/stop framing with a valid/ready word port.
// Define SER_RX_PARITY_EN to add an even parity bit per frame and the perr output.
module ser_rx
  import ser_pkg::*;
#(
  parameter int W         = SER_W,
  parameter int BIT_TICKS = SER_BIT_TICKS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rxd,
  output logic [W-1:0] data,
  output logic         valid,
  input  logic         ready,
  output logic         ferr,
  output logic         overrun
`ifdef SER_RX_PARITY_EN
  ,
  output logic         perr
`endif
);

  localparam int CW = $clog2(BIT_TICKS);
  localparam int BW = $clog2(W + 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_TICKS / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BIT_TICKS - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(W - 1);

  logic            sync1_q, sync2_q, rxd_s;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bitcnt_q, bitcnt_d;
  logic [W-1:0]    data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            overrun_q, overrun_d;
  logic            shift_en, frame_good, tick;
  logic [W-1:0]    sr;
`ifdef SER_RX_PARITY_EN
  logic            par_err_q, par_err_d;
  logic            perr_q, perr_d;
`endif

  assign rxd_s = sync2_q;
  assign tick  = (cnt_q == '0);

  rx_shreg #(.W(W)) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .sin      (rxd_s),
    .q        (sr)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitcnt_d   = bitcnt_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ferr_d     = 1'b0;
    overrun_d  = 1'b0;
    shift_en   = 1'b0;
    frame_good = 1'b0;
`ifdef SER_RX_PARITY_EN
    par_err_d  = par_err_q;
    perr_d     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rxd_s) begin
          state_d = IDLE;
        end else begin
          state_d  = DATA;
          cnt_d    = FULL_LOAD;
          bitcnt_d = '0;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_en = 1'b1;
          cnt_d    = FULL_LOAD;
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == LAST_BIT) begin
`ifdef SER_RX_PARITY_EN
            state_d = PAR;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef SER_RX_PARITY_EN
      PAR: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          par_err_d = (rxd_s != ^sr);
          cnt_d     = FULL_LOAD;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d    = IDLE;
          frame_good = rxd_s;
          ferr_d     = !rxd_s;
        end
      end
      default: state_d = IDLE;
    endcase

    // A completed frame takes priority over the accept that would clear valid.
    if (valid_q && ready) valid_d = 1'b0;
    if (frame_good) begin
      if (valid_q && !ready) begin
        overrun_d = 1'b1;
      end else begin
        data_d  = sr;
        valid_d = 1'b1;
      end
`ifdef SER_RX_PARITY_EN
      perr_d = par_err_q;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SER_RX_PARITY_EN
      par_err_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      sync1_q   <= rxd;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitcnt_q  <= bitcnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
`ifdef SER_RX_PARITY_EN
      par_err_q <= par_err_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign data    = data_q;
  assign valid   = valid_q;
  assign ferr    = ferr_q;
  assign overrun = overrun_q;
`ifdef SER_RX_PARITY_EN
  assign perr    = perr_q;
`endif

endmodule
